// File: rtl/my_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : my_alu_arbiter
// Brief    : Shares one ALU between two requesters using round-robin
//            arbitration. Captures the winning operands, holds them on the
//            ALU for the op latency, and returns the result together with
//            the requester id on a valid/ready response channel.
// Options  : ALU_ARB_STATS_EN adds stat_cnt0/stat_cnt1, saturating 16-bit
//            counts of completed response handshakes per requester.
// Revision : 1.0 - initial release
// ============================================================================
module my_alu_arbiter #(
    parameter int MOD_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_clr,
    input  logic [31:0] alu_r,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_id
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] stat_cnt0,
    output logic [15:0] stat_cnt1
`endif
);

    localparam logic [2:0]       c_op_mod    = 3'b111;
    localparam logic [CNT_W-1:0] c_cnt_mod   = CNT_W'(MOD_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_short = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;     // requester granted most recently (1 = req1)
    logic             r_id;       // requester owning the op in flight
    logic [CNT_W-1:0] r_cnt;      // remaining EXEC cycles
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_exec_last;
    logic             w_resp_fire;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;
    logic [2:0]       w_sel_op;

    // Grant only in IDLE; on a tie the requester not granted last wins
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = r_last;
                w_grant1 = ~r_last;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign w_accept    = w_grant0 | w_grant1;
    assign w_sel_a     = w_grant1 ? req1_a  : req0_a;
    assign w_sel_b     = w_grant1 ? req1_b  : req0_b;
    assign w_sel_op    = w_grant1 ? req1_op : req0_op;
    assign w_exec_last = (r_state == S_EXEC) && (r_cnt == '0);
    assign w_resp_fire = (r_state == S_RESP) && resp_ready;
    assign resp_valid  = (r_state == S_RESP);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> EXEC on accept, EXEC -> RESP on last cycle, RESP -> IDLE on handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_nxt = S_EXEC;
            S_EXEC:  if (w_exec_last) w_state_nxt = S_RESP;
            S_RESP:  if (w_resp_fire) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, latency countdown and result capture. The counter is
    // loaded with the op latency and EXEC ends when it reaches zero, so the
    // result is sampled one cycle after the operand hold window has elapsed,
    // giving accept-to-valid of latency+1 edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_clr   <= 1'b0;
            resp_data <= '0;
            resp_id   <= 1'b0;
            r_id      <= 1'b0;
            r_last    <= 1'b1;
            r_cnt     <= '0;
        end else begin
            alu_clr <= 1'b0;
            if (w_accept) begin
                alu_a   <= w_sel_a;
                alu_b   <= w_sel_b;
                alu_op  <= w_sel_op;
                alu_clr <= (w_sel_op == c_op_mod);
                r_id    <= w_grant1;
                r_last  <= w_grant1;
                r_cnt   <= (w_sel_op == c_op_mod) ? c_cnt_mod : c_cnt_short;
            end else if (r_state == S_EXEC) begin
                if (w_exec_last) begin
                    resp_data <= alu_r;
                    resp_id   <= r_id;
                end else begin
                    r_cnt <= r_cnt - c_cnt_one;
                end
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester count of completed response handshakes, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else if (w_resp_fire) begin
            if (!resp_id && (stat_cnt0 != 16'hFFFF)) begin
                stat_cnt0 <= stat_cnt0 + 16'd1;
            end
            if (resp_id && (stat_cnt1 != 16'hFFFF)) begin
                stat_cnt1 <= stat_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_my_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_alu_arbiter
// Brief    : Self-checking bench for my_alu_arbiter: directed vector table,
//            hand-written tie/stall/reset sequences and randomized traffic
//            checked against a transaction-level arbitration model.
//            Define ALU_ARB_STATS_EN to also exercise the statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_alu_arbiter;

    localparam int MOD_CYCLES = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [31:0] alu_a, alu_b, alu_r, resp_data;
    logic [2:0]  alu_op;
    logic        alu_clr, resp_valid, resp_id;
    logic        resp_ready = 1'b1;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_cnt0, stat_cnt1;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int clr_seen = 0;
    int mcnt = 0;
    bit last = 1'b1;

    always #5 clk = ~clk;

    my_alu_arbiter #(.MOD_CYCLES(MOD_CYCLES), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_clr(alu_clr),
        .alu_r(alu_r),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id)
`ifdef ALU_ARB_STATS_EN
        , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
    );

    // ALU behaviour: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 MOD
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a | b);
            3'b100:  return a + b;
            3'b101:  return a - b;
            3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return (b == 32'd0) ? 32'd0 : (a % b);
        endcase
    endfunction

    // Mod result only becomes valid MOD_CYCLES cycles after the clear pulse
    always @(negedge clk) begin
        if (alu_clr) begin
            mcnt = 0;
            clr_seen = clr_seen + 1;
        end else if (mcnt < 1000) begin
            mcnt = mcnt + 1;
        end
    end
    assign alu_r = (alu_op == 3'b111 && mcnt < MOD_CYCLES) ? 32'hDEADBEEF : alu_fn(alu_a, alu_b, alu_op);

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        check({nm, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
        check({nm, "_misc"}, {alu_op, alu_clr, resp_valid, resp_id, req0_ready, req1_ready, resp_data}, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // Expect requester w to be granted, take the accept edge, then withdraw and scramble its inputs
    task automatic send(input bit w);
        #1;
        check("grant", {62'd0, req1_ready, req0_ready}, w ? 64'd2 : 64'd1);
        clr_seen = 0;
        tick();
        acc_cyc = cyc;
        if (w) begin
            req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom);
        end else begin
            req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom);
        end
    endtask

    // Wait for the response, check it, optionally stall the consumer, then handshake
    task automatic collect(input bit id, input logic [31:0] d, input logic [2:0] op, input int stall);
        int n;
        int badstall;
        resp_ready = (stall == 0);
        n = 0;
        while (!resp_valid && n < MOD_CYCLES + 10) begin
            tick();
            n++;
        end
        if (!resp_valid) begin
            check("resp_timeout", {63'd0, resp_valid}, 64'd1);
            resp_ready = 1'b1;
            return;
        end
        check("latency", 64'(cyc - acc_cyc), (op == 3'b111) ? 64'(MOD_CYCLES + 1) : 64'd2);
        check("resp_data", {32'd0, resp_data}, {32'd0, d});
        check("resp_id", {63'd0, resp_id}, {63'd0, id});
        check("clr_pulses", 64'(clr_seen), (op == 3'b111) ? 64'd1 : 64'd0);
        badstall = 0;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (!resp_valid || resp_data !== d || resp_id !== id || req0_ready || req1_ready) badstall++;
        end
        if (stall > 0) check("stall_hold", 64'(badstall), 64'd0);
        resp_ready = 1'b1;
        tick();
        check("handshake", {63'd0, resp_valid}, 64'd0);
    endtask

    typedef struct {
        bit          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[9];

    initial begin
        bit          w;
        int          cnt;
        logic [31:0] e;
        logic [2:0]  o;

        vt[0] = '{1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000};
        vt[1] = '{1'b1, 32'h1234_0000, 32'h0000_5678, 3'b001, 32'h1234_5678};
        vt[2] = '{1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'b010, 32'hF0F0_0F0F};
        vt[3] = '{1'b1, 32'h0000_0000, 32'h0000_FFFF, 3'b011, 32'hFFFF_0000};
        vt[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 3'b100, 32'h0000_0001};
        vt[5] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 3'b101, 32'hFFFF_FFFE};
        vt[6] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 3'b110, 32'h0000_0001};
        vt[7] = '{1'b1, 32'd100,       32'd7,         3'b111, 32'd2};
        vt[8] = '{1'b0, 32'hFFFF_FFFF, 32'd10,        3'b111, 32'd5};

        // Reset values while reset is held
        #3;
        chk_zero("reset");
        do_reset();

`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < 5; i++) begin
            w = (i >= 3);
            drive(w, 32'(i), 32'd1, 3'b100);
            send(w);
            collect(w, 32'(i + 1), 3'b100, 0);
        end
        check("stat_cnt0", {48'd0, stat_cnt0}, 64'd3);
        check("stat_cnt1", {48'd0, stat_cnt1}, 64'd2);
        do_reset();
`endif

        // Directed single-requester vectors
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].id, vt[i].a, vt[i].b, vt[i].op);
            send(vt[i].id);
            collect(vt[i].id, vt[i].exp, vt[i].op, i % 3);
        end

        // Ties after reset: req0 first, then alternation
        do_reset();
        drive(0, 32'h0F00_0000, 32'h0000_00F0, 3'b001);
        drive(1, 32'hAAAA_5555, 32'hFFFF_0000, 3'b010);
        send(0);
        collect(0, 32'h0F00_00F0, 3'b001, 0);
        drive(0, 32'h1234_5678, 32'hFFFF_0000, 3'b000);
        send(1);
        collect(1, 32'h5555_5555, 3'b010, 0);
        send(0);
        collect(0, 32'h1234_0000, 3'b000, 0);

        // Consumer stall with req0 pending; next accept one cycle after handshake
        drive(0, 32'h0000_00FF, 32'h0000_0F0F, 3'b000);
        send(0);
        drive(0, 32'd3, 32'd4, 3'b100);
        collect(0, 32'h0000_000F, 3'b000, 10);
        check("ready_after_hs", {63'd0, req0_ready}, 64'd1);
        send(0);
        collect(0, 32'd7, 3'b100, 0);

        // Randomized traffic against the arbitration model
        do_reset();
        last = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) drive(0, $urandom, $urandom, 3'($urandom_range(0, 7)));
            if (!req1_valid && $urandom_range(0, 1) == 1) drive(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
            if (!req0_valid && !req1_valid) drive(it[0], $urandom, $urandom, 3'($urandom_range(0, 7)));
            w = (req0_valid && req1_valid) ? !last : req1_valid;
            last = w;
            e = w ? alu_fn(req1_a, req1_b, req1_op) : alu_fn(req0_a, req0_b, req0_op);
            o = w ? req1_op : req0_op;
            send(w);
            collect(w, e, o, $urandom_range(0, 3));
        end

        // Reset in the middle of a mod op aborts it
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        drive(1, 32'd100, 32'd7, 3'b111);
        send(1);
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        #3;
        reset = 1'b1;
        cnt = 0;
        repeat (MOD_CYCLES + 6) begin
            tick();
            if (resp_valid) cnt++;
        end
        check("no_resp_after_abort", 64'(cnt), 64'd0);
        drive(0, 32'd7, 32'd3, 3'b100);
        send(0);
        collect(0, 32'd10, 3'b100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
